// File: rtl/wb_io_arb_pkg.sv
// Shared types and constants for the Wishbone IO-port arbiter.
package wb_io_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned WB_AW       = 32;
    localparam int unsigned WB_DW       = 32;
    localparam int unsigned WB_SW       = 4;
    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned TO_W        = 16;
    localparam int unsigned IDX_W       = $clog2(MAX_MASTERS);

    // Master-to-slave signals that are forwarded from the granted master.
    typedef struct packed {
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
        logic             we;
        logic             stb;
        logic [2:0]       cti;
        logic [1:0]       bte;
    } wb_fwd_t;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx[0] = oh[1] | oh[3] | oh[5] | oh[7];
        idx[1] = oh[2] | oh[3] | oh[6] | oh[7];
        idx[2] = oh[4] | oh[5] | oh[6] | oh[7];
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant,
// in increasing index order with wrap-around.
module wb_rr_pick
    import wb_io_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [NUM_MASTERS-1:0] grant_next,
    output logic                   valid
);

    logic [NUM_MASTERS-1:0] above_mask;
    logic [NUM_MASTERS-1:0] upper;
    logic [NUM_MASTERS-1:0] pool;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_mask
        assign above_mask[i] = (32'(i) > 32'(last_grant));
    end

    // Prefer requesters above last_grant; otherwise wrap to the lowest requester.
    always_comb begin
        upper      = req & above_mask;
        pool       = (|upper) ? upper : req;
        grant_next = pool & (~pool + NUM_MASTERS'(1));
        valid      = |req;
    end

endmodule

// File: rtl/wb_io_arbiter.sv
// Round-robin Wishbone B4 arbiter sharing the IO master port among bus masters.
// Optional stall watchdog enabled by defining WB_IO_ARB_TIMEOUT_EN.
module wb_io_arbiter
    import wb_io_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic [NUM_MASTERS*WB_AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*WB_DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*WB_SW-1:0]   wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]         wbm_we_i,
    input  logic [NUM_MASTERS-1:0]         wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]         wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]       wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]       wbm_bte_i,
    output logic [WB_DW-1:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]         wbm_ack_o,
    output logic [NUM_MASTERS-1:0]         wbm_err_o,
    output logic [NUM_MASTERS-1:0]         wbm_rty_o,
    output logic [WB_AW-1:0]               wbs_adr_o,
    output logic [WB_DW-1:0]               wbs_dat_o,
    output logic [WB_SW-1:0]               wbs_sel_o,
    output logic                           wbs_we_o,
    output logic                           wbs_cyc_o,
    output logic                           wbs_stb_o,
    output logic [2:0]                     wbs_cti_o,
    output logic [1:0]                     wbs_bte_o,
    input  logic [WB_DW-1:0]               wbs_dat_i,
    input  logic                           wbs_ack_i,
    input  logic                           wbs_err_i,
    input  logic                           wbs_rty_i,
    output logic [NUM_MASTERS-1:0]         grant_o
);

    arb_state_e             state;
    arb_state_e             next_state;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       last_grant;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic                   pick_valid;
    logic                   gnt_cyc;
    logic                   in_grant;
    logic                   to_fire;

    wb_fwd_t m_req [NUM_MASTERS];
    wb_fwd_t chain [NUM_MASTERS+1];
    wb_fwd_t fwd;

    // Out-of-range parameter sets show up as this block in the elaborated hierarchy.
    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_config
    end

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req        (wbm_cyc_i),
        .last_grant (last_grant),
        .grant_next (pick_grant),
        .valid      (pick_valid)
    );

    // AND-OR mux: each master's slice is masked by its grant bit and OR-chained.
    assign chain[0] = '0;
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_mux
        assign m_req[i].adr = wbm_adr_i[i*WB_AW +: WB_AW];
        assign m_req[i].dat = wbm_dat_i[i*WB_DW +: WB_DW];
        assign m_req[i].sel = wbm_sel_i[i*WB_SW +: WB_SW];
        assign m_req[i].we  = wbm_we_i[i];
        assign m_req[i].stb = wbm_stb_i[i];
        assign m_req[i].cti = wbm_cti_i[i*3 +: 3];
        assign m_req[i].bte = wbm_bte_i[i*2 +: 2];
        assign chain[i+1]   = chain[i] | (m_req[i] & {$bits(wb_fwd_t){grant[i]}});
    end

    assign gnt_cyc = |(grant & wbm_cyc_i);

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state and grant-phase decode.
    always_comb begin
        next_state = state;
        in_grant   = 1'b0;
        case (state)
            IDLE:  if (pick_valid) next_state = GRANT;
            GRANT: begin
                in_grant = 1'b1;
                if (!gnt_cyc) next_state = IDLE;
            end
        endcase
    end

    // Grant register and round-robin pointer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            grant      <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
        end else if (state == IDLE && pick_valid) begin
            grant      <= pick_grant;
            last_grant <= onehot_to_idx(MAX_MASTERS'(pick_grant));
        end else if (state == GRANT && !gnt_cyc) begin
            grant      <= '0;
        end
    end

`ifdef WB_IO_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_count;
    logic            wd_stall;

    assign wd_stall = wbs_stb_o & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);

    // Stall watchdog: count unterminated strobe cycles, fire one err cycle at the limit.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !in_grant) begin
            to_count <= '0;
            to_fire  <= 1'b0;
        end else begin
            to_fire  <= wd_stall && (to_count == TO_W'(TIMEOUT_CYCLES - 1));
            to_count <= (wd_stall && to_count != TO_W'(TIMEOUT_CYCLES - 1))
                        ? to_count + TO_W'(1) : '0;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    // Slave-side forwarding, zeroed outside GRANT.
    always_comb begin
        fwd       = in_grant ? chain[NUM_MASTERS] : '0;
        wbs_adr_o = fwd.adr;
        wbs_dat_o = fwd.dat;
        wbs_sel_o = fwd.sel;
        wbs_we_o  = fwd.we;
        wbs_cti_o = fwd.cti;
        wbs_bte_o = fwd.bte;
        wbs_stb_o = fwd.stb & ~to_fire;
        wbs_cyc_o = in_grant & gnt_cyc;
    end

    // Responses routed to the granted master only; a watchdog cycle reports err alone.
    always_comb begin
        wbm_dat_o = wbs_dat_i;
        wbm_ack_o = grant & {NUM_MASTERS{in_grant & ~to_fire & wbs_ack_i}};
        wbm_rty_o = grant & {NUM_MASTERS{in_grant & ~to_fire & wbs_rty_i}};
        wbm_err_o = grant & {NUM_MASTERS{in_grant & (to_fire | wbs_err_i)}};
        grant_o   = grant;
    end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Self-checking bench for wb_io_arbiter (2 masters, TIMEOUT_CYCLES=8).
module tb_wb_io_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] m_adr;
    logic [63:0] m_dat;
    logic [7:0]  m_sel;
    logic [1:0]  m_we, m_cyc, m_stb;
    logic [5:0]  m_cti;
    logic [3:0]  m_bte;
    logic [31:0] s_dat;
    logic        s_ack, s_err, s_rty;

    logic [31:0] wbm_dat_o;
    logic [1:0]  wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    wb_io_arbiter #(
        .NUM_MASTERS    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (m_adr),
        .wbm_dat_i (m_dat),
        .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),
        .wbm_cyc_i (m_cyc),
        .wbm_stb_i (m_stb),
        .wbm_cti_i (m_cti),
        .wbm_bte_i (m_bte),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (s_dat),
        .wbs_ack_i (s_ack),
        .wbs_err_i (s_err),
        .wbs_rty_i (s_rty),
        .grant_o   (grant_o)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [31:0] adr0;
        logic [31:0] adr1;
        logic [2:0]  cti1;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic [1:0]  e_grant;
        logic        e_cyc;
        logic        e_stb;
        logic [31:0] e_adr;
        logic [2:0]  e_cti;
        logic [1:0]  e_ack;
        logic [1:0]  e_err;
    } vec_t;

    localparam int NV = 19;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] cyc, input logic [1:0] stb,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [2:0] c1,
                         input logic ack, input logic err, input logic [31:0] dat);
        rst   = r;
        m_cyc = cyc;
        m_stb = stb;
        m_adr = {a1, a0};
        m_cti = {c1, 3'b000};
        s_ack = ack;
        s_err = err;
        s_dat = dat;
    endtask

    task automatic check_row(input string tag, input logic [1:0] eg, input logic ec,
                             input logic es, input logic [31:0] ea, input logic [2:0] ect,
                             input logic [1:0] eack, input logic [1:0] eerr,
                             input logic [31:0] edat);
        chk({tag, ".grant"}, 32'(grant_o), 32'(eg));
        chk({tag, ".wbs_cyc"}, 32'(wbs_cyc_o), 32'(ec));
        chk({tag, ".wbs_stb"}, 32'(wbs_stb_o), 32'(es));
        chk({tag, ".wbs_adr"}, wbs_adr_o, ea);
        chk({tag, ".wbs_cti"}, 32'(wbs_cti_o), 32'(ect));
        chk({tag, ".ack_o"}, 32'(wbm_ack_o), 32'(eack));
        chk({tag, ".err_o"}, 32'(wbm_err_o), 32'(eerr));
        chk({tag, ".dat_o"}, wbm_dat_o, edat);
    endtask

    initial begin
        //            rst cyc    stb    adr0      adr1      cti1    ack  err  dat            grant  cyc  stb  adr       cti     ack    err
        tv[0]  = '{1'b0, 2'b00, 2'b00, 32'h00, 32'h00, 3'b000, 1'b1, 1'b0, 32'hDEAD0000, 2'b00, 1'b0, 1'b0, 32'h00, 3'b000, 2'b00, 2'b00};
        tv[1]  = '{1'b0, 2'b01, 2'b01, 32'h10, 32'h00, 3'b000, 1'b0, 1'b0, 32'h00000001, 2'b00, 1'b0, 1'b0, 32'h00, 3'b000, 2'b00, 2'b00};
        tv[2]  = '{1'b0, 2'b01, 2'b01, 32'h10, 32'h00, 3'b000, 1'b0, 1'b0, 32'h00000002, 2'b01, 1'b1, 1'b1, 32'h10, 3'b000, 2'b00, 2'b00};
        tv[3]  = '{1'b0, 2'b01, 2'b01, 32'h10, 32'h00, 3'b000, 1'b1, 1'b0, 32'hCAFE0001, 2'b01, 1'b1, 1'b1, 32'h10, 3'b000, 2'b01, 2'b00};
        tv[4]  = '{1'b0, 2'b00, 2'b00, 32'h10, 32'h00, 3'b000, 1'b0, 1'b0, 32'h00000004, 2'b01, 1'b0, 1'b0, 32'h10, 3'b000, 2'b00, 2'b00};
        tv[5]  = '{1'b1, 2'b00, 2'b00, 32'h00, 32'h00, 3'b000, 1'b0, 1'b0, 32'h00000005, 2'b00, 1'b0, 1'b0, 32'h00, 3'b000, 2'b00, 2'b00};
        tv[6]  = '{1'b0, 2'b11, 2'b11, 32'h20, 32'h30, 3'b000, 1'b0, 1'b0, 32'h00000006, 2'b00, 1'b0, 1'b0, 32'h00, 3'b000, 2'b00, 2'b00};
        tv[7]  = '{1'b0, 2'b11, 2'b11, 32'h20, 32'h30, 3'b000, 1'b1, 1'b0, 32'h00000007, 2'b01, 1'b1, 1'b1, 32'h20, 3'b000, 2'b01, 2'b00};
        tv[8]  = '{1'b0, 2'b10, 2'b10, 32'h20, 32'h30, 3'b000, 1'b0, 1'b0, 32'h00000008, 2'b01, 1'b0, 1'b0, 32'h20, 3'b000, 2'b00, 2'b00};
        tv[9]  = '{1'b0, 2'b10, 2'b10, 32'h20, 32'h30, 3'b000, 1'b0, 1'b0, 32'h00000009, 2'b00, 1'b0, 1'b0, 32'h00, 3'b000, 2'b00, 2'b00};
        tv[10] = '{1'b0, 2'b11, 2'b11, 32'h40, 32'h30, 3'b010, 1'b1, 1'b0, 32'h0000000A, 2'b10, 1'b1, 1'b1, 32'h30, 3'b010, 2'b10, 2'b00};
        tv[11] = '{1'b0, 2'b11, 2'b11, 32'h40, 32'h34, 3'b010, 1'b1, 1'b0, 32'h0000000B, 2'b10, 1'b1, 1'b1, 32'h34, 3'b010, 2'b10, 2'b00};
        tv[12] = '{1'b0, 2'b11, 2'b11, 32'h40, 32'h38, 3'b010, 1'b1, 1'b0, 32'h0000000C, 2'b10, 1'b1, 1'b1, 32'h38, 3'b010, 2'b10, 2'b00};
        tv[13] = '{1'b0, 2'b11, 2'b11, 32'h40, 32'h3C, 3'b111, 1'b1, 1'b0, 32'h0000000D, 2'b10, 1'b1, 1'b1, 32'h3C, 3'b111, 2'b10, 2'b00};
        tv[14] = '{1'b0, 2'b01, 2'b01, 32'h40, 32'h3C, 3'b111, 1'b0, 1'b0, 32'h0000000E, 2'b10, 1'b0, 1'b0, 32'h3C, 3'b111, 2'b00, 2'b00};
        tv[15] = '{1'b0, 2'b01, 2'b01, 32'h40, 32'h3C, 3'b111, 1'b0, 1'b0, 32'h0000000F, 2'b00, 1'b0, 1'b0, 32'h00, 3'b000, 2'b00, 2'b00};
        tv[16] = '{1'b0, 2'b01, 2'b01, 32'h40, 32'h3C, 3'b111, 1'b0, 1'b1, 32'h00000010, 2'b01, 1'b1, 1'b1, 32'h40, 3'b000, 2'b00, 2'b01};
        tv[17] = '{1'b0, 2'b00, 2'b00, 32'h40, 32'h3C, 3'b000, 1'b0, 1'b0, 32'h00000011, 2'b01, 1'b0, 1'b0, 32'h40, 3'b000, 2'b00, 2'b00};
        tv[18] = '{1'b0, 2'b00, 2'b00, 32'h00, 32'h00, 3'b000, 1'b0, 1'b0, 32'h00000012, 2'b00, 1'b0, 1'b0, 32'h00, 3'b000, 2'b00, 2'b00};

        m_dat = {32'hBBBB0001, 32'hAAAA0000};
        m_sel = 8'hF3;
        m_we  = 2'b00;
        m_bte = 4'b0000;
        s_rty = 1'b0;
        drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        #1;
        check_row("reset", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 2'b00, 32'h0);
        chk("reset.wbs_sel", 32'(wbs_sel_o), 32'h0);
        chk("reset.wbs_dat", wbs_dat_o, 32'h0);
        chk("reset.wbs_we", 32'(wbs_we_o), 32'h0);
        chk("reset.wbs_bte", 32'(wbs_bte_o), 32'h0);
        chk("reset.rty_o", 32'(wbm_rty_o), 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].cyc, tv[i].stb, tv[i].adr0, tv[i].adr1, tv[i].cti1,
                  tv[i].ack, tv[i].err, tv[i].dat);
            #1;
            check_row($sformatf("vec%0d", i), tv[i].e_grant, tv[i].e_cyc, tv[i].e_stb,
                      tv[i].e_adr, tv[i].e_cti, tv[i].e_ack, tv[i].e_err, tv[i].dat);
        end

        // Reset pulsed while master 1 owns the bus
        @(negedge clk);
        drive(1'b0, 2'b10, 2'b10, 32'h0, 32'h50, 3'b000, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rstmid.pre_grant", 32'(grant_o), 32'h0);
        @(negedge clk);
        #1;
        chk("rstmid.grant", 32'(grant_o), 32'h2);
        chk("rstmid.adr", wbs_adr_o, 32'h50);
        chk("rstmid.sel", 32'(wbs_sel_o), 32'hF);
        chk("rstmid.dat", wbs_dat_o, 32'hBBBB0001);
        @(negedge clk);
        drive(1'b1, 2'b10, 2'b10, 32'h0, 32'h50, 3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 2'b11, 2'b11, 32'h60, 32'h50, 3'b000, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rstmid.after_grant", 32'(grant_o), 32'h0);
        chk("rstmid.after_cyc", 32'(wbs_cyc_o), 32'h0);
        chk("rstmid.after_stb", 32'(wbs_stb_o), 32'h0);
        @(negedge clk);
        #1;
        chk("rstmid.regrant", 32'(grant_o), 32'h1);
        chk("rstmid.regrant_adr", wbs_adr_o, 32'h60);
        chk("rstmid.regrant_sel", 32'(wbs_sel_o), 32'h3);
        chk("rstmid.regrant_dat", wbs_dat_o, 32'hAAAA0000);
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);

        // Stalled slave: master 0 strobes, slave never terminates
        @(negedge clk);
        drive(1'b0, 2'b01, 2'b01, 32'h70, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0);
        #1;
        chk("stall.idle_grant", 32'(grant_o), 32'h0);
`ifdef WB_IO_ARB_TIMEOUT_EN
        for (int unsigned k = 1; k <= 12; k++) begin
            @(negedge clk);
            drive(1'b0, 2'b01, 2'b01, 32'h70, 32'h0, 3'b000, logic'(k == 9), 1'b0, 32'h0);
            #1;
            chk($sformatf("wd%0d.grant", k), 32'(grant_o), 32'h1);
            chk($sformatf("wd%0d.err_o", k), 32'(wbm_err_o), (k == 9) ? 32'h1 : 32'h0);
            chk($sformatf("wd%0d.wbs_stb", k), 32'(wbs_stb_o), (k == 9) ? 32'h0 : 32'h1);
            chk($sformatf("wd%0d.ack_o", k), 32'(wbm_ack_o), 32'h0);
        end
`else
        for (int unsigned k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stall%0d.grant", k), 32'(grant_o), 32'h1);
            chk($sformatf("stall%0d.err_o", k), 32'(wbm_err_o), 32'h0);
            chk($sformatf("stall%0d.wbs_stb", k), 32'(wbs_stb_o), 32'h1);
        end
`endif
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("end.grant", 32'(grant_o), 32'h0);
        chk("end.wbs_cyc", 32'(wbs_cyc_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
